// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target and its helpers.
//   i2c_state_e      : protocol FSM states of the target
//   I2C_ACK/I2C_NACK : SDA level of the acknowledge bit
//   I2C_DEFAULT_ADDR : default 7-bit bus address
//   ptr_next()       : register-pointer advance after an acknowledged byte
// Configuration macro: I2C_SLAVE_AUTOINC_EN (defined -> pointer auto-increments,
// wrapping 8'hFF -> 8'h00; undefined -> pointer only changes on the REG byte).
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

  function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
`ifdef I2C_SLAVE_AUTOINC_EN
    return ptr + 8'd1;
`else
    return ptr;
`endif
  endfunction

endpackage

// File: rtl/i2c_slave_line_cond.sv
// i2c_line_cond: SCL/SDA conditioner for I2C bus monitoring.
// Synchronises both pad levels through SYNC flops (reset to 1 = idle bus),
// keeps one previous-sample flop per line and derives single-clk events.
//   clk, rst    : system clock, async active-high reset
//   scl_i,sda_i : raw pad levels
//   sda_o       : synchronised SDA level
//   scl_rise_o  : SCL 0->1 seen this clk
//   scl_fall_o  : SCL 1->0 seen this clk
//   start_o     : SDA fell while SCL high (START / repeated START)
//   stop_o      : SDA rose while SCL high (STOP)
module i2c_line_cond #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC-1:0] scl_sync_q;
  logic [SYNC-1:0] sda_sync_q;
  logic            scl_prev_q;
  logic            sda_prev_q;
  logic            scl_s;
  logic            sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC-1];
      sda_prev_q <= sda_sync_q[SYNC-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC-1];
  assign sda_s = sda_sync_q[SYNC-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high in both samples so an SDA edge landing in the same clk
  // as an SCL edge is never mistaken for START/STOP.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target (no clock stretching) with a register-port interface.
// Answers 7-bit address ADDR, supports pointer writes, data writes and
// combined (repeated START) reads. Optional pointer auto-increment is
// enabled by the macro I2C_SLAVE_AUTOINC_EN.
//   clk, rst  : system clock, async active-high reset
//   scl_in    : SCL pad level (input only)
//   sda_in    : SDA pad level
//   sda_oe    : 1 = pull SDA low, 0 = release (open-drain)
//   reg_addr  : register pointer
//   reg_wdata : write data, valid while reg_we=1
//   reg_we    : one-clk write strobe
//   reg_re    : one-clk read strobe
//   reg_rdata : combinational read data for reg_addr
//   busy      : high from address match until START/STOP/NACK
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic sda_lvl;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_line_cond #(
    .SYNC(SYNC)
  ) u_cond (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_in),
    .sda_i     (sda_in),
    .sda_o     (sda_lvl),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (bus_start),
    .stop_o    (bus_stop)
  );

  i2c_state_e state_q;
  logic [2:0] cnt_q;
  logic       full_q;
  logic [7:0] shift_q;
  logic [6:0] tx_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       reg_re_q;
  logic       busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      shift_q     <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;

      if (bus_start) begin
        state_q  <= ST_ADDR;
        cnt_q    <= '0;
        full_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (bus_stop) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        full_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ST_ADDR, ST_REG, ST_WDATA: begin
            shift_q <= {shift_q[6:0], sda_lvl};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) full_q <= 1'b1;
          end
          ST_RDATA: begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) full_q <= 1'b1;
          end
          ST_RACK: begin
            if (sda_lvl == I2C_NACK) begin
              state_q <= ST_IGNORE;
              busy_q  <= 1'b0;
            end else begin
              // Pointer advances on the ACK sample rather than the following
              // SCL fall, so reg_rdata already reflects the new pointer when
              // the next byte is loaded at that fall.
              reg_addr_q <= ptr_next(reg_addr_q);
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ST_ADDR: begin
            if (full_q) begin
              full_q <= 1'b0;
              if (shift_q[7:1] == ADDR) begin
                state_q  <= ST_ADDR_ACK;
                rw_q     <= shift_q[0];
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (rw_q) begin
              state_q  <= ST_RDATA;
              reg_re_q <= 1'b1;
              tx_q     <= reg_rdata[6:0];
              sda_oe_q <= ~reg_rdata[7];
            end else begin
              state_q  <= ST_REG;
              sda_oe_q <= 1'b0;
            end
          end
          ST_REG: begin
            if (full_q) begin
              full_q     <= 1'b0;
              reg_addr_q <= shift_q;
              sda_oe_q   <= 1'b1;
              state_q    <= ST_REG_ACK;
            end
          end
          ST_REG_ACK: begin
            sda_oe_q <= 1'b0;
            state_q  <= ST_WDATA;
          end
          ST_WDATA: begin
            if (full_q) begin
              full_q      <= 1'b0;
              reg_wdata_q <= shift_q;
              reg_we_q    <= 1'b1;
              sda_oe_q    <= 1'b1;
              state_q     <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            sda_oe_q   <= 1'b0;
            reg_addr_q <= ptr_next(reg_addr_q);
            state_q    <= ST_WDATA;
          end
          ST_RDATA: begin
            if (full_q) begin
              full_q   <= 1'b0;
              sda_oe_q <= 1'b0;
              state_q  <= ST_RACK;
            end else begin
              tx_q     <= {tx_q[5:0], 1'b0};
              sda_oe_q <= ~tx_q[6];
            end
          end
          ST_RACK: begin
            // Only reached after a master ACK; NACK already left for IGNORE.
            state_q  <= ST_RDATA;
            reg_re_q <= 1'b1;
            tx_q     <= reg_rdata[6:0];
            sda_oe_q <= ~reg_rdata[7];
          end
          ST_IGNORE: begin
            sda_oe_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;

  localparam int NS = 60;
  localparam int HN = 30;
  localparam logic [6:0] MY_ADDR = 7'h50;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0] mem [256];

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];
  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];
  logic [7:0]  m_ptr;
  logic [7:0]  wbuf [8];

  always #5 clk = ~clk;

  // Open-drain wired-AND with pull-up.
  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_slave #(
    .ADDR(MY_ADDR),
    .SYNC(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (!rst && reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (!rst && reg_re) re_q.push_back(reg_addr);
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: finish=not_reached required=reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(HN); sda_m = 1'b1;
    wait_clk(HN); scl_m = 1'b1;
    wait_clk(HN); sda_m = 1'b0;
    wait_clk(HN); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(HN); sda_m = 1'b0;
    wait_clk(HN); scl_m = 1'b1;
    wait_clk(HN); sda_m = 1'b1;
    wait_clk(NS);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(HN); sda_m = b;
    wait_clk(HN); scl_m = 1'b1;
    wait_clk(NS); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(HN); sda_m = 1'b1;
    wait_clk(HN); scl_m = 1'b1;
    wait_clk(HN); b = sda_bus;
    wait_clk(HN); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    send_bit(mack);
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_we_count"}, we_q.size(), exp_we.size());
    for (int i = 0; i < we_q.size() && i < exp_we.size(); i++)
      check({tag, "_we_addr_data"}, we_q[i], exp_we[i]);
    check({tag, "_re_count"}, re_q.size(), exp_re.size());
    for (int i = 0; i < re_q.size() && i < exp_re.size(); i++)
      check({tag, "_re_addr"}, re_q[i], exp_re[i]);
    we_q.delete(); re_q.delete(); exp_we.delete(); exp_re.delete();
  endtask

  // Write transaction: address a, wbuf[0] is the pointer, wbuf[1..n-1] data.
  task automatic do_write(input string tag, input logic [6:0] a, input int n);
    logic ack;
    logic hit;
    hit = (a == MY_ADDR);
    bus_start();
    send_byte({a, 1'b0}, ack);
    check({tag, "_addr_ack"}, ack, hit ? 0 : 1);
    check({tag, "_busy_after_addr"}, busy, hit ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      check({tag, "_byte_ack"}, ack, hit ? 0 : 1);
      if (hit) begin
        if (i == 0) m_ptr = wbuf[0];
        else begin
          exp_we.push_back({m_ptr, wbuf[i]});
          if (AUTOINC) m_ptr = m_ptr + 8'd1;
        end
      end
    end
    bus_stop();
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_reg_addr_end"}, reg_addr, m_ptr);
    check_queues(tag);
  endtask

  // Read transaction of n bytes, optionally preceded by a pointer write + Sr.
  task automatic do_read(input string tag, input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] v;
    bus_start();
    if (set_ptr) begin
      send_byte({MY_ADDR, 1'b0}, ack);
      check({tag, "_waddr_ack"}, ack, 0);
      send_byte(p, ack);
      check({tag, "_ptr_ack"}, ack, 0);
      m_ptr = p;
      bus_start();
    end
    send_byte({MY_ADDR, 1'b1}, ack);
    check({tag, "_raddr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_re.push_back(m_ptr);
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, v);
      check({tag, "_rdata"}, v, mem[m_ptr]);
      if (i != n - 1 && AUTOINC) m_ptr = m_ptr + 8'd1;
    end
    check({tag, "_busy_after_nack"}, busy, 0);
    check({tag, "_sda_oe_after_nack"}, sda_oe, 0);
    bus_stop();
    check({tag, "_reg_addr_end"}, reg_addr, m_ptr);
    check_queues(tag);
  endtask

  initial begin
    logic ack;
    logic [7:0] p;
    int n;
    logic [6:0] a;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; m_ptr = 8'h00;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clk(10);

    // Simple write
    wbuf[0] = 8'h03; wbuf[1] = 8'h5A;
    do_write("wr1", MY_ADDR, 2);

    // Combined read with master NACK
    mem[8'h07] = 8'hC3;
    do_read("rd1", 1'b1, 8'h07, 1);

    // Address miss (0xA2)
    wbuf[0] = 8'h11;
    do_write("miss", 7'h51, 1);

    // Burst write across pointer wrap
    wbuf[0] = 8'hFE; wbuf[1] = 8'h11; wbuf[2] = 8'h22; wbuf[3] = 8'h33;
    do_write("burst", MY_ADDR, 4);

    // Randomised transactions
    for (int it = 0; it < 3; it++) begin
      n = 1 + int'($urandom_range(2, 0));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(3, 0) == 0) a = MY_ADDR ^ 7'(1 + $urandom_range(126, 0));
      else a = MY_ADDR;
      do_write("rnd_wr", a, n);
      n = 1 + int'($urandom_range(1, 0));
      do_read("rnd_rd", $urandom_range(1, 0) == 1, 8'($urandom), n);
    end

    // Async reset while the target drives a 0 data bit
    p = 8'($urandom);
    mem[p] = 8'($urandom) & 8'h7F;
    bus_start();
    send_byte({MY_ADDR, 1'b0}, ack);
    check("rstmid_waddr_ack", ack, 0);
    send_byte(p, ack);
    check("rstmid_ptr_ack", ack, 0);
    bus_start();
    send_byte({MY_ADDR, 1'b1}, ack);
    check("rstmid_raddr_ack", ack, 0);
    wait_clk(HN);
    check("rstmid_driving_bit7", sda_oe, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_sda_oe", sda_oe, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_reg_addr", reg_addr, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    m_ptr = 8'h00;
    exp_re.push_back(p);
    check_queues("rstmid");
    wait_clk(10);

    // STOP after 3 data bits of a write byte, then a fresh addressing
    p = 8'($urandom);
    bus_start();
    send_byte({MY_ADDR, 1'b0}, ack);
    check("trunc_addr_ack", ack, 0);
    send_byte(p, ack);
    check("trunc_ptr_ack", ack, 0);
    m_ptr = p;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    bus_stop();
    check("trunc_busy", busy, 0);
    check("trunc_reg_addr", reg_addr, m_ptr);
    check_queues("trunc");
    bus_start();
    send_byte({MY_ADDR, 1'b0}, ack);
    check("after_trunc_ack", ack, 0);
    check("after_trunc_busy", busy, 1);
    bus_stop();
    check("after_trunc_busy_end", busy, 0);
    check_queues("after_trunc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
